// File: rtl/ysyx_22051086_muldiv_sched.sv
// EX-stage sequencer driving one multi-cycle mul or div unit per instruction.
// Latency: request 1 cycle after accept; res_valid 1 cycle after unit out_valid.
// Backpressure: holds {mul,div}_valid until ready, stalls EX via busy, holds res until res_ack.
module ysyx_22051086_muldiv_sched #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            res_ack,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] res,
  output logic            timeout_err,
  output logic [XLEN-1:0] op_src1,
  output logic [XLEN-1:0] op_src2,
  output logic            op_word,
  output logic            op_signed,
  output logic            unit_flush,
  output logic            mul_valid,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_res_lo,
  output logic            div_valid,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last WAIT cycle index before the watchdog fires (counter starts at 0).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        sel_div;
  logic        sel_rem;

  logic        dec_mul, dec_div, dec_word, dec_signed, dec_rem;
  logic        accept;
  logic        req_fire;
  logic        unit_done;
  logic        capture;
  logic        tmo_hit;

  // Decode the aluop into unit select and operation flavour.
  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_word   = 1'b0;
    dec_signed = 1'b0;
    dec_rem    = 1'b0;
    case (aluop)
      5'b01000: begin dec_mul = 1'b1; dec_word = 1'b1; dec_signed = 1'b1; end
      5'b01101: begin dec_mul = 1'b1; dec_signed = 1'b1; end
      5'b01001: begin dec_div = 1'b1; dec_word = 1'b1; dec_signed = 1'b1; end
      5'b01010: begin dec_div = 1'b1; dec_word = 1'b1; dec_signed = 1'b1; dec_rem = 1'b1; end
      5'b10010: begin dec_div = 1'b1; end
      5'b10011: begin dec_div = 1'b1; dec_word = 1'b1; end
      5'b10100: begin dec_div = 1'b1; dec_word = 1'b1; dec_rem = 1'b1; end
      5'b10101: begin dec_div = 1'b1; dec_rem = 1'b1; end
      5'b10110: begin dec_div = 1'b1; dec_signed = 1'b1; end
      default: ;
    endcase
  end

  assign accept    = (state == S_IDLE) & ex_valid & (dec_mul | dec_div) & ~flush;
  assign req_fire  = (state == S_REQ) & (sel_div ? div_ready : mul_ready);
  assign unit_done = sel_div ? div_out_valid : mul_out_valid;
  // A completion racing a flush is dropped; flush always wins.
  assign capture   = (state == S_WAIT) & unit_done & ~flush;
  // A result arriving on the last allowed cycle is kept rather than aborted.
  assign tmo_hit   = (state == S_WAIT) & (cnt == TMO_LAST) & ~unit_done & ~flush;

  // Request lines are pure decodes of registered state, so they are glitch-free.
  assign mul_valid = (state == S_REQ) & ~sel_div;
  assign div_valid = (state == S_REQ) & sel_div;
  assign res_valid = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, stall and abort pulses.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    unit_flush  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_IDLE: begin
        busy = accept;
        if (accept) state_nxt = S_REQ;
      end
      S_REQ: begin
        busy = 1'b1;
        if (flush) begin
          unit_flush = 1'b1;
          state_nxt  = S_IDLE;
        end else if (req_fire) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (flush) begin
          unit_flush = 1'b1;
          state_nxt  = S_IDLE;
        end else if (capture) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          unit_flush  = 1'b1;
          timeout_err = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_DONE: begin
        // Retire (or discard on flush); a new op is only seen back in IDLE.
        if (flush || res_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch operands and operation flavour when an op is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_src1   <= '0;
      op_src2   <= '0;
      op_word   <= 1'b0;
      op_signed <= 1'b0;
      sel_div   <= 1'b0;
      sel_rem   <= 1'b0;
    end else if (accept) begin
      op_src1   <= src1;
      op_src2   <= src2;
      op_word   <= dec_word;
      op_signed <= dec_signed;
      sel_div   <= dec_div;
      sel_rem   <= dec_rem;
    end
  end

  // Watchdog: cleared on request handshake, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (req_fire)         cnt <= '0;
    else if (state == S_WAIT)  cnt <= cnt + 8'd1;
  end

  // Capture the selected unit result; held stable through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (capture) begin
      if (!sel_div)     res <= mul_res_lo;
      else if (sel_rem) res <= div_remainder;
      else              res <= div_quotient;
    end
  end

endmodule

// File: tb/tb_ysyx_22051086_muldiv_sched.sv
// Bench for the mul/div sequencer: simple unit models, queue scoreboard.
// Latency: checks request/response timing cycle by cycle.
// Backpressure: exercises ready stalls, DONE hold, flush, timeout and reset.
module tb_ysyx_22051086_muldiv_sched;

  localparam int XLEN = 64;
  localparam logic [63:0] QTAG = 64'h0F0F_1234_0F0F_5678;
  localparam logic [63:0] RTAG = 64'h3C3C_A5A5_C3C3_5A5A;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid;
  logic [4:0]      aluop;
  logic [XLEN-1:0] src1, src2;
  logic            flush, res_ack;
  logic            busy, res_valid, timeout_err;
  logic [XLEN-1:0] res, op_src1, op_src2;
  logic            op_word, op_signed, unit_flush;
  logic            mul_valid, mul_ready, mul_out_valid;
  logic [XLEN-1:0] mul_res_lo;
  logic            div_valid, div_ready, div_out_valid;
  logic [XLEN-1:0] div_quotient, div_remainder;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // Unit models: result buses derived from the latched operands.
  assign mul_res_lo    = op_src1 * op_src2;
  assign div_quotient  = op_src1 ^ QTAG;
  assign div_remainder = op_src2 ^ RTAG;

  ysyx_22051086_muldiv_sched #(.XLEN(XLEN), .TIMEOUT(128)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .aluop(aluop),
    .src1(src1), .src2(src2), .flush(flush), .res_ack(res_ack),
    .busy(busy), .res_valid(res_valid), .res(res), .timeout_err(timeout_err),
    .op_src1(op_src1), .op_src2(op_src2), .op_word(op_word), .op_signed(op_signed),
    .unit_flush(unit_flush),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
    .mul_res_lo(mul_res_lo),
    .div_valid(div_valid), .div_ready(div_ready), .div_out_valid(div_out_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to 2ns after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Accept an op and complete the request handshake immediately; ends in WAIT cycle 1.
  task automatic issue(input logic [4:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input bit is_div);
    ex_valid = 1'b1; aluop = op; src1 = s1; src2 = s2;
    tick;
    ex_valid = 1'b0;
    if (is_div) div_ready = 1'b1; else mul_ready = 1'b1;
    tick;
    mul_ready = 1'b0; div_ready = 1'b0;
  endtask

  // Full op: accept, request (ready after rdy_dly), response after rsp_dly WAIT cycles,
  // DONE held ack_dly cycles, then retire.
  task automatic run_op(input string nm, input logic [4:0] op,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input bit is_div, input bit word, input bit sgn,
                        input logic [63:0] exp, input int rdy_dly, input int rsp_dly,
                        input int ack_dly);
    int vcnt;
    logic [63:0] held;
    ex_valid = 1'b1; aluop = op; src1 = s1; src2 = s2;
    #1;
    chk({nm, "_accept_busy"}, 64'(busy), 64'd1);
    chk({nm, "_accept_noreq"}, 64'(mul_valid | div_valid), 64'd0);
    exp_q.push_back(exp);
    tick;
    ex_valid = 1'b0; src1 = ~s1; src2 = ~s2;
    #1;
    chk({nm, "_op_word"}, 64'(op_word), 64'(word));
    chk({nm, "_op_signed"}, 64'(op_signed), 64'(sgn));
    chk({nm, "_op_src1"}, op_src1, s1);
    chk({nm, "_op_src2"}, op_src2, s2);
    vcnt = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      if (is_div) div_ready = (i == rdy_dly); else mul_ready = (i == rdy_dly);
      #1;
      if (is_div ? div_valid : mul_valid) vcnt++;
      if ((is_div ? mul_valid : div_valid) || !busy)
        chk({nm, "_req_phase"}, {62'd0, busy, is_div ? mul_valid : div_valid}, 64'd2);
      tick;
    end
    mul_ready = 1'b0; div_ready = 1'b0;
    chk({nm, "_valid_cycles"}, 64'(vcnt), 64'(rdy_dly + 1));
    #1;
    chk({nm, "_wait_valid_dropped"}, 64'(mul_valid | div_valid), 64'd0);
    for (int i = 1; i < rsp_dly; i++) begin
      if (!busy || res_valid)
        chk({nm, "_wait_phase"}, {62'd0, busy, res_valid}, 64'd2);
      tick;
      #1;
    end
    if (is_div) div_out_valid = 1'b1; else mul_out_valid = 1'b1;
    #1;
    chk({nm, "_resp_cycle_res_valid"}, 64'(res_valid), 64'd0);
    chk({nm, "_resp_cycle_busy"}, 64'(busy), 64'd1);
    tick;
    mul_out_valid = 1'b0; div_out_valid = 1'b0;
    #1;
    chk({nm, "_done_res_valid"}, 64'(res_valid), 64'd1);
    chk({nm, "_done_busy"}, 64'(busy), 64'd0);
    if (exp_q.size() == 0) chk({nm, "_sb_empty"}, 64'd0, 64'd1);
    else                   chk({nm, "_res"}, res, exp_q.pop_front());
    held = res;
    for (int i = 0; i < ack_dly; i++) begin
      tick;
      #1;
      if (res !== held || !res_valid)
        chk({nm, "_done_hold"}, res, held ^ {63'd0, ~res_valid});
    end
    res_ack = 1'b1;
    tick;
    res_ack = 1'b0;
    #1;
    chk({nm, "_ack_clears"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int seen;
    rst_n = 1'b0; ex_valid = 1'b0; aluop = '0; src1 = '0; src2 = '0;
    flush = 1'b0; res_ack = 1'b0; mul_ready = 1'b0; mul_out_valid = 1'b0;
    div_ready = 1'b0; div_out_valid = 1'b0;
    tick; tick;
    chk("reset_ctrl", {58'd0, busy, res_valid, timeout_err, unit_flush, mul_valid, div_valid}, 64'd0);
    chk("reset_res", res, 64'd0);
    chk("reset_ops", op_src1 | op_src2 | {62'd0, op_word, op_signed}, 64'd0);
    rst_n = 1'b1;
    tick;

    // 1: signed mul, immediate ready, response on 3rd WAIT cycle
    run_op("mul", 5'b01101, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFEB, 0, 3, 0);
    // 2: remw, ready low 4 cycles -> valid held 5
    run_op("remw", 5'b01010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1,
           64'd2 ^ RTAG, 4, 2, 1);
    // divu quotient and mulw
    run_op("divu", 5'b10010, 64'h1234_5678_9ABC_DEF0, 64'd3, 1'b1, 1'b0, 1'b0,
           64'h1234_5678_9ABC_DEF0 ^ QTAG, 1, 1, 0);
    run_op("mulw", 5'b01000, 64'h0000_0001_0000_0003, 64'd5, 1'b0, 1'b1, 1'b1,
           64'h0000_0005_0000_000F, 2, 1, 0);
    run_op("remu", 5'b10101, 64'd100, 64'd9, 1'b1, 1'b0, 1'b0, 64'd9 ^ RTAG, 0, 1, 0);

    // Non-mul/div op: ignored
    ex_valid = 1'b1; aluop = 5'b00011;
    #1;
    chk("nonmd_busy", 64'(busy), 64'd0);
    tick;
    ex_valid = 1'b0;
    #1;
    chk("nonmd_noreq", 64'(mul_valid | div_valid | busy), 64'd0);

    // 3: flush two cycles into WAIT, late out_valid ignored
    issue(5'b01101, 64'd3, 64'd4, 1'b0);
    tick; tick;
    flush = 1'b1;
    #1;
    chk("flush_uflush", 64'(unit_flush), 64'd1);
    chk("flush_no_tmo", 64'(timeout_err), 64'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("flush_after", {61'd0, unit_flush, busy, res_valid}, 64'd0);
    mul_out_valid = 1'b1;
    tick;
    mul_out_valid = 1'b0;
    #1;
    chk("flush_late_outv", {62'd0, res_valid, busy}, 64'd0);

    // Flush in the same cycle as out_valid: result dropped
    issue(5'b10110, 64'd50, 64'd7, 1'b1);
    div_out_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_race_uflush", 64'(unit_flush), 64'd1);
    tick;
    div_out_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_race_drop", {62'd0, res_valid, busy}, 64'd0);

    // Unselected unit out_valid ignored in WAIT
    issue(5'b10011, 64'd77, 64'd8, 1'b1);
    exp_q.push_back(64'd77 ^ QTAG);
    mul_out_valid = 1'b1;
    tick;
    mul_out_valid = 1'b0;
    #1;
    chk("unsel_ignored", {62'd0, res_valid, busy}, 64'd1);
    div_out_valid = 1'b1;
    tick;
    div_out_valid = 1'b0;
    #1;
    chk("unsel_then_done", 64'(res_valid), 64'd1);
    chk("unsel_res", res, exp_q.pop_front());
    // Flush in DONE discards without unit_flush
    flush = 1'b1;
    #1;
    chk("done_flush_no_uflush", 64'(unit_flush), 64'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("done_flush_idle", 64'(res_valid), 64'd0);

    // 4: timeout at 128th WAIT cycle
    issue(5'b01101, 64'd9, 64'd9, 1'b0);
    seen = 0;
    for (int c = 1; c <= 200 && seen == 0; c++) begin
      #1;
      if (timeout_err) begin
        seen = c;
        chk("tmo_uflush", 64'(unit_flush), 64'd1);
      end
      tick;
    end
    chk("tmo_cycle", 64'(seen), 64'd128);
    #1;
    chk("tmo_after", {60'd0, busy, res_valid, timeout_err, unit_flush}, 64'd0);
    tick;

    // 5: DONE held 5 cycles, then back-to-back second op
    run_op("hold", 5'b01001, 64'd1000, 64'd10, 1'b1, 1'b1, 1'b1, 64'd1000 ^ QTAG, 0, 2, 5);
    run_op("b2b", 5'b01101, 64'd6, 64'd6, 1'b0, 1'b0, 1'b1, 64'd36, 0, 1, 0);

    // 6: async reset while in REQ
    ex_valid = 1'b1; aluop = 5'b01101; src1 = 64'd11; src2 = 64'd12;
    tick;
    ex_valid = 1'b0;
    #1;
    chk("rst_pre_req", 64'(mul_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {58'd0, busy, res_valid, timeout_err, unit_flush, mul_valid, div_valid}, 64'd0);
    chk("rst_data", res | op_src1 | op_src2, 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    run_op("post_rst", 5'b10100, 64'd21, 64'd4, 1'b1, 1'b1, 1'b0, 64'd4 ^ RTAG, 1, 2, 0);

    if (exp_q.size() != 0) chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
